lcd_win_ctrl: RTL and testbench
===============================

# lcd_win_ctrl

Parametrised successor to the fixed 6x6/3x3 LCD image controller. It stores an IMG_W x IMG_H pixel image loaded over a byte stream and streams a WIN x WIN window of it on command. Window moves and the output stream are cycle-exact. New over the previous generation: generic sizes, output backpressure (`dout_ready`), horizontal-mirror mode and a recentre command. Sits between the host command interface and the LCD pixel driver.

## Interface
- `DW`, 8, pixel width in bits
- `IMG_W`, 6, image width in pixels, ≥ WIN
- `IMG_H`, 6, image height in pixels, ≥ WIN
- `WIN`, 3, window edge in pixels, ≥ 1
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `cmd`  in  3  command code, sampled with `cmd_valid`
- `cmd_valid`  in  1  command strobe
- `datain`  in  DW  load pixel stream
- `dout_ready`  in  1  downstream accepts current beat
- `dataout`  out  DW  window pixel
- `output_valid`  out  1  `dataout` valid
- `busy`  out  1  command in progress; `cmd_valid` ignored while high

## Operation
- Commands:
  - 0 OUTPUT: stream the window.
  - 1 LOAD: load an image, set origin to centre, then OUTPUT.
  - 2 RIGHT: x+1 clamped at IMG_W-WIN, then OUTPUT.
  - 3 LEFT: x-1 clamped at 0, then OUTPUT.
  - 4 UP: y-1 clamped at 0, then OUTPUT.
  - 5 DOWN: y+1 clamped at IMG_H-WIN, then OUTPUT.
  - 6 MIRROR: toggle `mirror`, then OUTPUT.
  - 7 CENTRE: set origin to centre, then OUTPUT.
- Centre origin: x0=(IMG_W-WIN+1)/2, y0=(IMG_H-WIN+1)/2. For defaults this is (2,2).
- A shift at the boundary leaves the origin unchanged but still outputs.
- States:
  - IDLE: accept when `cmd_valid` && !`busy`; go to LOAD for cmd 1, otherwise EXEC.
  - LOAD: N=IMG_W*IMG_H cycles, one pixel per cycle in raster order (row 0 col 0 first); then EXEC.
  - EXEC: 1 cycle; apply the origin/mirror update; go to OUT.
  - OUT: WIN*WIN beats; return to IDLE.
- OUT beat k (0..WIN*WIN-1): row r=k/WIN, col c=k%WIN. Pixel address = (y+r)*IMG_W + (x+c'), where c'=c normally and c'=WIN-1-c when `mirror`=1.
- Beat counter and address use widths of ceil(log2(WIN*WIN+1)) and ceil(log2(IMG_W*IMG_H)). Arithmetic is unsigned, with no wrap; clamping guarantees the address stays in range.
- `mirror` persists across commands. Only cmd 6 or reset changes it; LOAD does not clear it.

## Timing
- Reset values: `dataout`=0, `output_valid`=0, `busy`=0, state IDLE, origin = centre, `mirror`=0, beat/load counters 0. Pixel memory is not reset.
- Command accepted at edge T: `busy`=1 after edge T.
- LOAD: pixel i is sampled on edge T+1+i (i=0..N-1). EXEC runs on edge T+N+1. First beat is valid after edge T+N+2.
- Other commands: EXEC on edge T+1; first beat is valid after edge T+2.
- A beat is transferred on an edge with `output_valid` && `dout_ready`; the next beat is presented after that edge. While `dout_ready`=0, `dataout` and `output_valid` hold.
- Last beat transferred at edge E: `output_valid`=0 and `busy`=0 after E. A new command may be accepted at E+1.
- Reset mid-LOAD or mid-OUT: everything returns to reset values immediately; a partially written image remains in memory.
- `datain` is ignored outside LOAD.

## Structure
- Package `lcd_ctrl_pkg`: command encodings (CMD_OUTPUT..CMD_CENTRE) and the state enum (IDLE, LOAD, EXEC, OUT).
- Sub-module `lcd_pixel_mem`: IMG_W*IMG_H x DW register array, 1 synchronous write port, 1 combinational read port. `dataout` is registered in the controller.

## Test plan
- Reset, LOAD pixels 0..35 (defaults): 9 beats 14,15,16,20,21,22,26,27,28; `busy` falls after the last beat.
- RIGHT x2 after load: first RIGHT outputs 15,16,17,21,22,23,27,28,29; second RIGHT is clamped and outputs the same 9 values.
- UP x3 then LEFT x3: ends at origin (0,0) with output 0,1,2,6,7,8,12,13,14.
- MIRROR at centre: 16,15,14,22,21,20,28,27,26; a second MIRROR restores normal order.
- `dout_ready` low for 5 cycles at beat 4: `dataout`=21 held with `output_valid` high, no beat skipped or duplicated. A `cmd_valid` pulse while busy is ignored.
- Reset asserted at load pixel 10, then CENTRE: `busy` drops immediately. Window at (2,2) shows the new values for addresses <10 and the old values for the rest.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
// Shared definitions for the LCD window controller: host command codes,
// controller state encoding and a small width helper.
package lcd_ctrl_pkg;

  // Host command codes, sampled together with cmd_valid
  typedef enum logic [2:0] {
    CMD_OUTPUT = 3'd0,
    CMD_LOAD   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_LEFT   = 3'd3,
    CMD_UP     = 3'd4,
    CMD_DOWN   = 3'd5,
    CMD_MIRROR = 3'd6,
    CMD_CENTRE = 3'd7
  } cmd_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Bits needed to index 0..v-1, never less than one bit
  function automatic int clog2_min1(input int v);
    if (v > 1) begin
      return $clog2(v);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/lcd_pixel_mem.sv
// lcd_pixel_mem
// Image store: DEPTH x DW register array with one synchronous write port and
// one combinational read port. Contents are deliberately not reset so that a
// partially loaded image survives a reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational; zero for an address past the array)
module lcd_pixel_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 36,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:DEPTH-1];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read port with an out-of-range guard
  always_comb begin
    if ({1'b0, raddr} < (AW+1)'(DEPTH)) begin
      rdata = mem_r[raddr];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl
// Stores an IMG_W x IMG_H image received one pixel per cycle and streams a
// WIN x WIN window of it on command, with clamped window moves, horizontal
// mirroring, recentring and output backpressure.
//   clk          - rising-edge clock
//   reset        - asynchronous, active-high
//   cmd          - command code, sampled with cmd_valid
//   cmd_valid    - command strobe (ignored while busy)
//   datain       - image pixel stream, used only while loading
//   dout_ready   - downstream accepts the current beat
//   dataout      - window pixel (registered)
//   output_valid - dataout holds a valid beat
//   busy         - a command is in progress
module lcd_win_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int WIN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] datain,
  input  logic          dout_ready,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int N    = IMG_W * IMG_H;
  localparam int NB   = WIN * WIN;
  localparam int AW   = clog2_min1(N);
  localparam int BW   = $clog2(NB + 1);
  localparam int XW   = clog2_min1(IMG_W);
  localparam int YW   = clog2_min1(IMG_H);
  localparam int CW   = clog2_min1(WIN);
  localparam int RW   = $clog2(WIN + 1);
  localparam int X0   = (IMG_W - WIN + 1) / 2;
  localparam int Y0   = (IMG_H - WIN + 1) / 2;
  localparam int XMAX = IMG_W - WIN;
  localparam int YMAX = IMG_H - WIN;

  state_e        state_r,  state_nx;
  cmd_e          cmd_r,    cmd_nx;
  logic [XW-1:0] x_r,      x_nx;
  logic [YW-1:0] y_r,      y_nx;
  logic          mirror_r, mirror_nx;
  logic [AW-1:0] load_r,   load_nx;
  logic [BW-1:0] beat_r,   beat_nx;
  logic [RW-1:0] row_r,    row_nx;
  logic [CW-1:0] col_r,    col_nx;
  logic [DW-1:0] dout_r,   dout_nx;
  logic          valid_r,  valid_nx;
  logic          busy_r,   busy_nx;

  logic          we_s;
  logic [CW-1:0] col_eff_s;
  logic [AW-1:0] pix_addr_s;
  logic [DW-1:0] rdata_s;

  lcd_pixel_mem #(
    .DW    (DW),
    .DEPTH (N),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (load_r),
    .wdata (datain),
    .raddr (pix_addr_s),
    .rdata (rdata_s)
  );

  // Address of the pixel for the next beat; the row/col counters walk the
  // window in raster order so no divider is needed for beat/WIN, beat%WIN.
  always_comb begin
    col_eff_s = col_r;
    if (mirror_r) begin
      col_eff_s = CW'(WIN - 1) - col_r;
    end else begin
      col_eff_s = col_r;
    end
    pix_addr_s = (AW'(y_r) + AW'(row_r)) * AW'(IMG_W) + AW'(x_r) + AW'(col_eff_s);
  end

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    state_nx  = state_r;
    cmd_nx    = cmd_r;
    x_nx      = x_r;
    y_nx      = y_r;
    mirror_nx = mirror_r;
    load_nx   = load_r;
    beat_nx   = beat_r;
    row_nx    = row_r;
    col_nx    = col_r;
    dout_nx   = dout_r;
    valid_nx  = valid_r;
    we_s      = 1'b0;

    case (state_r)
      // busy is low exactly while in IDLE, so a strobe here is always accepted
      IDLE: begin
        if (cmd_valid) begin
          cmd_nx  = cmd_e'(cmd);
          load_nx = '0;
          if (cmd_e'(cmd) == CMD_LOAD) begin
            state_nx = LOAD;
          end else begin
            state_nx = EXEC;
          end
        end else begin
          state_nx = IDLE;
        end
      end

      LOAD: begin
        we_s = 1'b1;
        if (load_r == AW'(N - 1)) begin
          load_nx  = '0;
          state_nx = EXEC;
        end else begin
          load_nx  = load_r + AW'(1);
          state_nx = LOAD;
        end
      end

      EXEC: begin
        beat_nx  = '0;
        row_nx   = '0;
        col_nx   = '0;
        valid_nx = 1'b0;
        state_nx = OUT;
        case (cmd_r)
          CMD_OUTPUT: begin
            x_nx = x_r;
          end
          CMD_LOAD, CMD_CENTRE: begin
            x_nx = XW'(X0);
            y_nx = YW'(Y0);
          end
          CMD_RIGHT: begin
            if (x_r < XW'(XMAX)) begin
              x_nx = x_r + XW'(1);
            end else begin
              x_nx = x_r;
            end
          end
          CMD_LEFT: begin
            if (x_r != XW'(0)) begin
              x_nx = x_r - XW'(1);
            end else begin
              x_nx = x_r;
            end
          end
          CMD_UP: begin
            if (y_r != YW'(0)) begin
              y_nx = y_r - YW'(1);
            end else begin
              y_nx = y_r;
            end
          end
          CMD_DOWN: begin
            if (y_r < YW'(YMAX)) begin
              y_nx = y_r + YW'(1);
            end else begin
              y_nx = y_r;
            end
          end
          CMD_MIRROR: begin
            mirror_nx = ~mirror_r;
          end
          default: begin
            x_nx = x_r;
          end
        endcase
      end

      // A new beat is loaded when the output register is empty or its beat
      // is being taken; once all beats are out, the final take ends the command.
      OUT: begin
        if (!valid_r || dout_ready) begin
          if (beat_r < BW'(NB)) begin
            dout_nx  = rdata_s;
            valid_nx = 1'b1;
            beat_nx  = beat_r + BW'(1);
            if (col_r == CW'(WIN - 1)) begin
              col_nx = '0;
              row_nx = row_r + RW'(1);
            end else begin
              col_nx = col_r + CW'(1);
              row_nx = row_r;
            end
          end else begin
            valid_nx = 1'b0;
            beat_nx  = '0;
            row_nx   = '0;
            col_nx   = '0;
            state_nx = IDLE;
          end
        end else begin
          valid_nx = valid_r;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cmd_r    <= CMD_OUTPUT;
      x_r      <= XW'(X0);
      y_r      <= YW'(Y0);
      mirror_r <= 1'b0;
      load_r   <= '0;
      beat_r   <= '0;
      row_r    <= '0;
      col_r    <= '0;
      dout_r   <= '0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cmd_r    <= cmd_nx;
      x_r      <= x_nx;
      y_r      <= y_nx;
      mirror_r <= mirror_nx;
      load_r   <= load_nx;
      beat_r   <= beat_nx;
      row_r    <= row_nx;
      col_r    <= col_nx;
      dout_r   <= dout_nx;
      valid_r  <= valid_nx;
      busy_r   <= busy_nx;
    end
  end

  assign dataout      = dout_r;
  assign output_valid = valid_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// tb_lcd_win_ctrl
// Directed self-checking bench for lcd_win_ctrl at default sizes. Expected
// window pixels come from a bench-side image/origin model and are queued when
// a command is issued, then popped as beats are transferred.
module tb_lcd_win_ctrl;

  localparam int DW    = 8;
  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int WIN   = 3;
  localparam int N     = IMG_W * IMG_H;
  localparam int NB    = WIN * WIN;
  localparam int CX    = (IMG_W - WIN + 1) / 2;
  localparam int CY    = (IMG_H - WIN + 1) / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] datain;
  logic          dout_ready;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  always #5 clk = ~clk;

  lcd_win_ctrl #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .dout_ready   (dout_ready),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] img_m [N];
  int            mx, my;
  bit            mmir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input int c);
    case (c)
      1, 7: begin mx = CX; my = CY; end
      2: if (mx < IMG_W - WIN) mx++;
      3: if (mx > 0) mx--;
      4: if (my > 0) my--;
      5: if (my < IMG_H - WIN) my++;
      6: mmir = !mmir;
      default: ;
    endcase
  endtask

  task automatic push_window();
    for (int k = 0; k < NB; k++) begin
      int r, c;
      r = k / WIN;
      c = k % WIN;
      if (mmir) c = WIN - 1 - c;
      exp_q.push_back(img_m[(my + r) * IMG_W + mx + c]);
    end
  endtask

  // Issue a command at a negedge; returns just after the accepting edge
  task automatic issue(input logic [2:0] c);
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clk);
  endtask

  // Collect NB beats, optionally stalling at one beat and poking cmd_valid
  task automatic collect(input int stall_at, input bit poke);
    int got, stalls, cyc;
    got = 0; stalls = 0; cyc = 0;
    while (got < NB && cyc < 100) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      if (got == stall_at && stalls < 5 && output_valid) begin
        dout_ready = 1'b0;
        stalls++;
        check("stall_data", dataout, exp_q[0]);
        check("stall_valid", output_valid, 1);
        if (poke && stalls == 1) begin
          cmd       = 3'd2;
          cmd_valid = 1'b1;
        end
      end else begin
        dout_ready = 1'b1;
        if (output_valid) begin
          check($sformatf("beat%0d", got), dataout, exp_q.pop_front());
          got++;
        end
      end
    end
    check("beats_received", got, NB);
    @(negedge clk);
    check("valid_low_after_last", output_valid, 0);
    check("busy_low_after_last", busy, 0);
    exp_q.delete();
  endtask

  task automatic do_cmd(input logic [2:0] c, input int stall_at, input bit poke, input bit lat);
    issue(c);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("valid_in_exec", output_valid, 0);
    model_cmd(c);
    push_window();
    if (lat) begin
      @(negedge clk);
      check("lat_valid_after_exec", output_valid, 0);
      dout_ready = 1'b0;
      @(negedge clk);
      check("lat_first_beat_valid", output_valid, 1);
    end
    collect(stall_at, poke);
  endtask

  // LOAD with pixel base+i; abort_at >= 0 asserts reset before that pixel
  task automatic do_load(input int base, input int abort_at);
    issue(3'd1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", output_valid, 0);
        check("abort_dataout", dataout, 0);
        @(negedge clk);
        reset = 1'b0;
        mx = CX; my = CY; mmir = 1'b0;
        return;
      end
      if (i == 0) check("busy_in_load", busy, 1);
      datain   = DW'(base + i);
      img_m[i] = DW'(base + i);
    end
    model_cmd(1);
    push_window();
    collect(-1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    cmd        = 3'd0;
    cmd_valid  = 1'b0;
    datain     = '0;
    dout_ready = 1'b1;
    mx = CX; my = CY; mmir = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_dataout", dataout, 0);
    check("reset_valid", output_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    do_load(0, -1);                     // 14,15,16,20,21,22,26,27,28
    do_cmd(3'd0, -1, 1'b0, 1'b1);       // OUTPUT with latency checks
    do_cmd(3'd2, -1, 1'b0, 1'b0);       // RIGHT -> x=3
    do_cmd(3'd2, -1, 1'b0, 1'b0);       // RIGHT clamped
    for (int i = 0; i < 3; i++) do_cmd(3'd4, -1, 1'b0, 1'b0);  // UP x3
    for (int i = 0; i < 3; i++) do_cmd(3'd3, -1, 1'b0, 1'b0);  // LEFT x3 -> (0,0)
    do_cmd(3'd7, -1, 1'b0, 1'b0);       // CENTRE
    do_cmd(3'd6, -1, 1'b0, 1'b0);       // MIRROR on
    do_cmd(3'd6, -1, 1'b0, 1'b0);       // MIRROR off
    do_cmd(3'd0, 4, 1'b1, 1'b0);        // stall at beat 4, ignored RIGHT pulse
    do_cmd(3'd0, -1, 1'b0, 1'b0);       // origin unchanged by the pulse
    for (int i = 0; i < 3; i++) do_cmd(3'd5, -1, 1'b0, 1'b0);  // DOWN x3, clamped

    do_load(100, 10);                   // reset at pixel 10
    do_cmd(3'd7, -1, 1'b0, 1'b0);       // CENTRE: old values
    do_cmd(3'd4, -1, 1'b0, 1'b0);
    do_cmd(3'd4, -1, 1'b0, 1'b0);
    do_cmd(3'd3, -1, 1'b0, 1'b0);
    do_cmd(3'd3, -1, 1'b0, 1'b0);       // (0,0): mix of new and old

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
